udp_reg_ring_master: RTL and testbench
======================================

// Module: udp_reg_ring_master
// PURPOSE
//  Initiator end of the UDP register ring. Turns single host accesses into ring requests.
//  Drives the first ring stage (reg_*_out) and receives the last stage (reg_*_in).
//  Returns read data or write acknowledge to the host.
//  One transaction in flight. A timeout catches requests that never return.
// PARAMETERS
//  UDP_REG_SRC_WIDTH  2     width of reg_src tag
//  SRC_ID             0     tag driven on reg_src_out; only matching returns complete
//  TIMEOUT            1024  cycles from issue to forced completion (TIMEOUT_EN only)
// PORTS
//  clk              in   1    clock
//  reset_n          in   1    asynchronous reset, active low
//  host_req         in   1    access request; sampled only in IDLE
//  host_rd_wr_L     in   1    1=read, 0=write
//  host_addr        in   `UDP_REG_ADDR_WIDTH    register address
//  host_wr_data     in   `CPCI_NF2_DATA_WIDTH   write data
//  host_ack         out  1    one-cycle completion pulse
//  host_rd_data     out  `CPCI_NF2_DATA_WIDTH   read data, valid with host_ack
//  host_err         out  1    with host_ack: unacked return or timeout
//  host_busy        out  1    high whenever state != IDLE
//  reg_req_out      out  1    ring request
//  reg_ack_out      out  1    ring ack (always driven 0)
//  reg_rd_wr_L_out  out  1    ring direction
//  reg_addr_out     out  `UDP_REG_ADDR_WIDTH    ring address
//  reg_data_out     out  `CPCI_NF2_DATA_WIDTH   ring data
//  reg_src_out      out  UDP_REG_SRC_WIDTH      ring source tag (= SRC_ID)
//  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
//                   in   as the _out ports       ring return from the last stage
// BEHAVIOUR
//  - Reset (async, reset_n=0) clears all outputs and the state to IDLE.
//    Exceptions: reg_src_out=SRC_ID; reg_data_out and host_rd_data reset to 0.
//  - States:
//    IDLE: if host_req, register address, direction and data (write data; 0 on read) onto reg_*_out.
//          Set reg_req_out=1 on the next edge. Go to WAIT. Clear the timeout counter.
//    WAIT: hold all reg_*_out stable, reg_req_out=1.
//          Return = reg_req_in && reg_src_in==SRC_ID && reg_addr_in==reg_addr_out.
//          On return: reg_req_out<=0; host_ack pulses 1 cycle.
//          host_rd_data<=reg_data_in on read with ack, or 32'hdead_beef if !reg_ack_in.
//          host_err<=!reg_ack_in. Go to DRAIN.
//          Returns with a mismatched src or addr are ignored.
//    DRAIN: wait for reg_req_in==0 for one cycle, then go to IDLE. This prevents a stale return completing the next access.
//  - Latency: reg_req_out rises 1 cycle after host_req is sampled.
//    host_ack rises 1 cycle after the return is sampled.
//  - host_req asserted in WAIT or DRAIN is ignored; the host must hold it or re-present it.
//  - host_ack and host_err are pulses; host_rd_data holds until the next completion.
//  - Returns arriving in IDLE or DRAIN produce no host_ack.
// CONFIGURATION
//  UDP_REG_MASTER_TIMEOUT_EN defined:
//  - A $clog2(TIMEOUT+1)-bit counter increments in WAIT.
//  - When the counter reaches TIMEOUT-1 with no return in that cycle:
//    reg_req_out<=0, host_ack=1, host_err=1, host_rd_data=32'hdead_beef. Go to DRAIN.
//  - A return in the same cycle as expiry wins and is completed normally.
//  Not defined: no counter; WAIT persists until a return or reset.
// TESTING
//  1 Read, ring loopback with 3-stage delay; stage answers ack=1 data=32'h1234_5678.
//    -> reg_req_out rises 1 clk after host_req; host_ack 1 clk after return; host_rd_data=32'h1234_5678; host_err=0.
//  2 Write to addr 23'h40_0001 data=32'hcafe_f00d, answered ack=1.
//    -> reg_data_out=32'hcafe_f00d held through WAIT; host_ack=1, host_err=0.
//  3 Return with ack=0 (no block decoded the address).
//    -> host_ack=1, host_err=1, host_rd_data=32'hdead_beef.
//  4 TIMEOUT_EN, TIMEOUT=16, ring never returns.
//    -> host_ack and host_err at cycle 16 after issue; reg_req_out=0; next access accepted only after reg_req_in is low.
//  5 Return with src=SRC_ID+1 during WAIT, then a correct return.
//    -> first ignored, second completes; exactly one host_ack.
//  6 reset_n low mid-WAIT.
//    -> reg_req_out=0, host_busy=0 immediately; a new access after release completes normally.

Source files
------------

// File: rtl/udp_reg_ring_master.sv
// Initiator of the UDP register ring: converts one host access at a time into a ring request.
// Optional request timeout enabled by defining UDP_REG_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_ring_master #(
  parameter int unsigned UDP_REG_SRC_WIDTH = 2,
  parameter int unsigned SRC_ID            = 0,
  parameter int unsigned TIMEOUT           = 1024
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              host_req,
  input  logic                              host_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]    host_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   host_wr_data,
  output logic                              host_ack,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]   host_rd_data,
  output logic                              host_err,
  output logic                              host_busy,
  output logic                              reg_req_out,
  output logic                              reg_ack_out,
  output logic                              reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out,
  input  logic                              reg_req_in,
  input  logic                              reg_ack_in,
  input  logic                              reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in
);

  localparam int unsigned ADDR_W = `UDP_REG_ADDR_WIDTH;
  localparam int unsigned DATA_W = `CPCI_NF2_DATA_WIDTH;
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hdead_beef);
  localparam logic [UDP_REG_SRC_WIDTH-1:0] MY_SRC = UDP_REG_SRC_WIDTH'(SRC_ID);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("udp_reg_ring_master: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

  state_t              state, state_n;
  logic                req_n, rd_wr_n, ack_n, err_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   data_n, rd_data_n;
  logic                ret_c;

  // Ring direction on the return path carries no information the master needs.
  logic unused_in;
  assign unused_in = reg_rd_wr_L_in;

`ifdef UDP_REG_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_n;
`endif

  // A return only counts if it carries our tag and the address we issued.
  assign ret_c = reg_req_in && (reg_src_in == MY_SRC) && (reg_addr_in == reg_addr_out);

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    req_n     = reg_req_out;
    rd_wr_n   = reg_rd_wr_L_out;
    addr_n    = reg_addr_out;
    data_n    = reg_data_out;
    rd_data_n = host_rd_data;
    ack_n     = 1'b0;
    err_n     = 1'b0;
`ifdef UDP_REG_MASTER_TIMEOUT_EN
    cnt_n     = cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (host_req) begin
          req_n   = 1'b1;
          rd_wr_n = host_rd_wr_L;
          addr_n  = host_addr;
          data_n  = host_rd_wr_L ? '0 : host_wr_data;
          state_n = ST_WAIT;
`ifdef UDP_REG_MASTER_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      ST_WAIT: begin
`ifdef UDP_REG_MASTER_TIMEOUT_EN
        cnt_n = cnt + CNT_W'(1);
`endif
        if (ret_c) begin
          req_n   = 1'b0;
          ack_n   = 1'b1;
          err_n   = !reg_ack_in;
          if (!reg_ack_in)
            rd_data_n = ERR_DATA;
          else if (reg_rd_wr_L_out)
            rd_data_n = reg_data_in;
          state_n = ST_DRAIN;
        end
`ifdef UDP_REG_MASTER_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          req_n     = 1'b0;
          ack_n     = 1'b1;
          err_n     = 1'b1;
          rd_data_n = ERR_DATA;
          state_n   = ST_DRAIN;
        end
`endif
      end
      ST_DRAIN: begin
        // Let any in-flight copy of our request leave the ring before the next access.
        if (!reg_req_in) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= MY_SRC;
      host_ack        <= 1'b0;
      host_err        <= 1'b0;
      host_rd_data    <= '0;
      host_busy       <= 1'b0;
`ifdef UDP_REG_MASTER_TIMEOUT_EN
      cnt             <= '0;
`endif
    end else begin
      state           <= state_n;
      reg_req_out     <= req_n;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= rd_wr_n;
      reg_addr_out    <= addr_n;
      reg_data_out    <= data_n;
      reg_src_out     <= MY_SRC;
      host_ack        <= ack_n;
      host_err        <= err_n;
      host_rd_data    <= rd_data_n;
      host_busy       <= (state_n != ST_IDLE);
`ifdef UDP_REG_MASTER_TIMEOUT_EN
      cnt             <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Directed bench for udp_reg_ring_master with a 3-stage ring loopback responder.
`timescale 1ns/1ps

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_ring_master;

  localparam int unsigned AW  = `UDP_REG_ADDR_WIDTH;
  localparam int unsigned DW  = `CPCI_NF2_DATA_WIDTH;
  localparam int unsigned SW  = 2;
  localparam int unsigned SRC = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          host_req, host_rd_wr_L;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wr_data;
  logic          host_ack, host_err, host_busy;
  logic [DW-1:0] host_rd_data;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [SW-1:0] reg_src_in;

  int vectors = 0;
  int miscompares = 0;
  int ack_cnt = 0;
  int acks0;

  logic          resp_ack = 1'b1;
  logic [DW-1:0] resp_data = 32'h1234_5678;
  logic          bad_src = 1'b0;
  logic          bad_addr = 1'b0;

  logic          s_req  [3];
  logic          s_rw   [3];
  logic [AW-1:0] s_addr [3];
  logic [DW-1:0] s_data [3];
  logic [SW-1:0] s_src  [3];

  always #5 clk = ~clk;

  udp_reg_ring_master #(.UDP_REG_SRC_WIDTH(SW), .SRC_ID(SRC), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_req(host_req), .host_rd_wr_L(host_rd_wr_L), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_ack(host_ack), .host_rd_data(host_rd_data),
    .host_err(host_err), .host_busy(host_busy),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  // Three ring stages; the last one answers reads with resp_data.
  always_ff @(posedge clk) begin
    s_req[0] <= reg_req_out; s_rw[0] <= reg_rd_wr_L_out; s_addr[0] <= reg_addr_out;
    s_data[0] <= reg_data_out; s_src[0] <= reg_src_out;
    for (int i = 1; i < 3; i++) begin
      s_req[i] <= s_req[i-1]; s_rw[i] <= s_rw[i-1]; s_addr[i] <= s_addr[i-1];
      s_data[i] <= s_data[i-1]; s_src[i] <= s_src[i-1];
    end
  end

  assign reg_req_in     = s_req[2];
  assign reg_ack_in     = resp_ack;
  assign reg_rd_wr_L_in = s_rw[2];
  assign reg_addr_in    = bad_addr ? (s_addr[2] ^ AW'(1)) : s_addr[2];
  assign reg_src_in     = bad_src ? (s_src[2] + SW'(1)) : s_src[2];
  assign reg_data_in    = s_rw[2] ? resp_data : s_data[2];

  always_ff @(posedge clk) if (host_ack) ack_cnt <= ack_cnt + 1;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    host_req = 1'b1; host_rd_wr_L = rd; host_addr = addr; host_wr_data = data;
    step;
    host_req = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!host_ack && n < 30) begin step; n++; end
    chk(tag, 64'(host_ack), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (host_busy && n < 30) begin step; n++; end
    chk(tag, 64'(host_busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; host_req = 1'b0; host_rd_wr_L = 1'b0; host_addr = '0; host_wr_data = '0;
    repeat (3) step;
    chk("rst_req", 64'(reg_req_out), 64'd0);
    chk("rst_busy", 64'(host_busy), 64'd0);
    chk("rst_ack", 64'(host_ack), 64'd0);
    chk("rst_src", 64'(reg_src_out), 64'(SRC));
    chk("rst_data", 64'(reg_data_out), 64'd0);
    chk("rst_rd_data", 64'(host_rd_data), 64'd0);
    chk("rst_ring_ack", 64'(reg_ack_out), 64'd0);
    reset_n = 1'b1;
    step;

    // 1: read, exact latencies
    host_req = 1'b1; host_rd_wr_L = 1'b1; host_addr = 23'h00_0010; host_wr_data = 32'hffff_ffff;
    chk("t1_req_pre", 64'(reg_req_out), 64'd0);
    step;
    host_req = 1'b0;
    chk("t1_req_rise", 64'(reg_req_out), 64'd1);
    chk("t1_busy", 64'(host_busy), 64'd1);
    chk("t1_rd_data_out", 64'(reg_data_out), 64'd0);
    chk("t1_addr_out", 64'(reg_addr_out), 64'h10);
    chk("t1_dir_out", 64'(reg_rd_wr_L_out), 64'd1);
    repeat (3) begin step; chk("t1_no_ack", 64'(host_ack), 64'd0); end
    chk("t1_ret_seen", 64'(reg_req_in), 64'd1);
    step;
    chk("t1_ack", 64'(host_ack), 64'd1);
    chk("t1_rd_data", 64'(host_rd_data), 64'h1234_5678);
    chk("t1_err", 64'(host_err), 64'd0);
    chk("t1_req_fall", 64'(reg_req_out), 64'd0);
    host_req = 1'b1;
    step;
    host_req = 1'b0;
    chk("t1_ack_pulse", 64'(host_ack), 64'd0);
    chk("t1_drain_ignore", 64'(reg_req_out), 64'd0);
    chk("t1_drain_busy", 64'(host_busy), 64'd1);
    wait_idle("t1_idle");
    chk("t1_rd_hold", 64'(host_rd_data), 64'h1234_5678);

    // 2: write, data held through WAIT
    issue(1'b0, 23'h40_0001, 32'hcafe_f00d);
    chk("t2_req", 64'(reg_req_out), 64'd1);
    chk("t2_dir", 64'(reg_rd_wr_L_out), 64'd0);
    chk("t2_addr", 64'(reg_addr_out), 64'h40_0001);
    chk("t2_data", 64'(reg_data_out), 64'hcafe_f00d);
    step; step;
    chk("t2_data_held", 64'(reg_data_out), 64'hcafe_f00d);
    chk("t2_req_held", 64'(reg_req_out), 64'd1);
    wait_ack("t2_ack");
    chk("t2_err", 64'(host_err), 64'd0);
    wait_idle("t2_idle");

    // 3: unacknowledged return
    resp_ack = 1'b0;
    issue(1'b1, 23'h00_0020, '0);
    wait_ack("t3_ack");
    chk("t3_err", 64'(host_err), 64'd1);
    chk("t3_rd_data", 64'(host_rd_data), 64'hdead_beef);
    step;
    chk("t3_err_pulse", 64'(host_err), 64'd0);
    resp_ack = 1'b1;
    wait_idle("t3_idle");

    // 5: foreign source tag ignored, then correct return completes once
    bad_src = 1'b1; resp_data = 32'h5555_aaaa;
    acks0 = ack_cnt;
    issue(1'b1, 23'h00_0030, '0);
    repeat (8) step;
    chk("t5_busy", 64'(host_busy), 64'd1);
    chk("t5_req_held", 64'(reg_req_out), 64'd1);
    chk("t5_no_ack", 64'(ack_cnt - acks0), 64'd0);
    bad_src = 1'b0;
    wait_ack("t5_ack");
    chk("t5_rd_data", 64'(host_rd_data), 64'h5555_aaaa);
    wait_idle("t5_idle");
    repeat (4) step;
    chk("t5_one_ack", 64'(ack_cnt - acks0), 64'd1);

`ifdef UDP_REG_MASTER_TIMEOUT_EN
    // 4: ring never answers our address
    bad_addr = 1'b1;
    issue(1'b1, 23'h00_0040, '0);
    chk("t4_req", 64'(reg_req_out), 64'd1);
    repeat (15) begin step; chk("t4_no_ack", 64'(host_ack), 64'd0); end
    step;
    chk("t4_ack", 64'(host_ack), 64'd1);
    chk("t4_err", 64'(host_err), 64'd1);
    chk("t4_rd_data", 64'(host_rd_data), 64'hdead_beef);
    chk("t4_req_fall", 64'(reg_req_out), 64'd0);
    chk("t4_ring_busy", 64'(reg_req_in), 64'd1);
    host_req = 1'b1;
    step;
    host_req = 1'b0;
    chk("t4_drain_busy", 64'(host_busy), 64'd1);
    chk("t4_drain_ignore", 64'(reg_req_out), 64'd0);
    bad_addr = 1'b0;
    wait_idle("t4_idle");
`endif

    // 6: asynchronous reset mid-WAIT
    resp_data = 32'h1234_5678;
    issue(1'b1, 23'h00_0050, '0);
    step;
    #1 reset_n = 1'b0;
    #1;
    chk("t6_req", 64'(reg_req_out), 64'd0);
    chk("t6_busy", 64'(host_busy), 64'd0);
    chk("t6_rd_data", 64'(host_rd_data), 64'd0);
    step; step;
    reset_n = 1'b1;
    repeat (4) step;
    issue(1'b1, 23'h00_0060, '0);
    chk("t6_req_after", 64'(reg_req_out), 64'd1);
    wait_ack("t6_ack");
    chk("t6_rd_data_after", 64'(host_rd_data), 64'h1234_5678);
    chk("t6_err", 64'(host_err), 64'd0);
    wait_idle("t6_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
